// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction
// field positions, FSM states and the immediate sign-extension helper.
package alu_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_ONE = 3'b111;

    localparam int OP_LSB  = 29;
    localparam int RD_LSB  = 26;
    localparam int RS1_LSB = 23;
    localparam int RS2_LSB = 20;
    localparam int IMM_BIT = 19;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_unit_reg_file.sv
// 8x32 register file: two combinational read ports, one synchronous
// write port, R0 hardwired to zero, asynchronous active-low clear.
module reg_file
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != 3'd0) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == 3'd0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == 3'd0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the 32-bit ALU: serialises instructions through
// IDLE -> EXEC -> WB, registering operands and writing results back.
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] operand_1,
    output logic [31:0] operand_2,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_rd,
    input  logic        out_ready,
    output logic [15:0] retired_count
);

    state_t state_q, state_d;

    logic [2:0]  op_f, rd_f, rs1_f, rs2_f;
    logic        use_imm_f;
    logic [15:0] imm_f;
    logic [2:0]  unused_reserved;

    logic [31:0] rf_a, rf_b, src2, op2_d;
    logic [31:0] op1_q, op2_q, result_q;
    logic [2:0]  ctl_q, rd_q;
    logic [15:0] count_q;
    logic        accept, retire;

    assign op_f      = in_instr[OP_LSB +: 3];
    assign rd_f      = in_instr[RD_LSB +: 3];
    assign rs1_f     = in_instr[RS1_LSB +: 3];
    assign rs2_f     = in_instr[RS2_LSB +: 3];
    assign use_imm_f = in_instr[IMM_BIT];
    assign imm_f     = in_instr[IMM_LSB +: 16];
    assign unused_reserved = in_instr[18:16];

    reg_file u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs1_f),
        .ra_data (rf_a),
        .rb_addr (rs2_f),
        .rb_data (rf_b),
        .we      (retire),
        .wa      (rd_q),
        .wd      (result_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Shifts only honour the low five bits of the shift amount.
    always_comb begin
        src2  = use_imm_f ? sext16(imm_f) : rf_b;
        op2_d = src2;
        unique case (1'b1)
            (op_f == OP_SHL),
            (op_f == OP_SHR): op2_d = {27'b0, src2[4:0]};
            default:          op2_d = src2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q    <= '0;
            op2_q    <= '0;
            ctl_q    <= OP_ADD;
            rd_q     <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                op1_q <= rf_a;
                op2_q <= op2_d;
                ctl_q <= op_f;
                rd_q  <= rd_f;
            end
            if (state_q == EXEC) result_q <= alu_result;
            if (retire)          count_q  <= count_q + 16'd1;
        end
    end

    assign operand_1     = op1_q;
    assign operand_2     = op2_q;
    assign alu_control   = ctl_q;
    assign out_data      = result_q;
    assign out_rd        = rd_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU and
// register-file reference model.
module tb_alu_issue_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [31:0] operand_1, operand_2;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_rd;
    logic        out_ready;
    logic [15:0] retired_count;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .operand_1     (operand_1),
        .operand_2     (operand_2),
        .alu_control   (alu_control),
        .alu_result    (alu_result),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_ready     (out_ready),
        .retired_count (retired_count)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOT:  return ~a;
            OP_SHL:  return a << b[4:0];
            OP_SHR:  return a >> b[4:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 32'd1;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_control, operand_1, operand_2);

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_regs [8];
    logic [15:0] exp_retired = 16'd0;
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = (ready_mode == 1);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_rd", {29'b0, out_rd}, {29'b0, e.rd});
                    check("retired_count", {16'b0, retired_count}, {16'b0, exp_retired});
                    exp_retired = exp_retired + 16'd1;
                end
            end
        end
    end

    function automatic logic [31:0] rd_ref(input logic [2:0] r);
        return (r == 3'd0) ? 32'd0 : ref_regs[r];
    endfunction

    // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic ui, input logic [15:0] imm);
        int n = 0;
        logic [31:0] a, b, r;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        in_instr = {op, rd, rs1, rs2, ui, 3'($urandom_range(0, 7)), imm};
        in_valid = 1'b1;
        a = rd_ref(rs1);
        b = ui ? {{16{imm[15]}}, imm} : rd_ref(rs2);
        if (op == OP_SHL || op == OP_SHR) b = b % 32;
        r = alu_ref(op, a, b);
        if (rd != 3'd0) ref_regs[rd] = r;
        sb.push_back('{data: r, rd: rd});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        logic [31:0] d0;
        logic [15:0] c0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", {29'b0, out_rd}, 32'd0);
        check("rst_retired", {16'b0, retired_count}, 32'd0);
        check("rst_operand_1", operand_1, 32'd0);
        check("rst_operand_2", operand_2, 32'd0);
        check("rst_alu_control", {29'b0, alu_control}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);
        issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFD);
        drain();
        check("retired_after_two", {16'b0, retired_count}, 32'd2);

        issue(OP_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
        check("lat_out_valid_t1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_out_valid_t2", {31'b0, out_valid}, 32'd1);
        check("sub_value", out_data, 32'h0000_0008);
        drain();

        issue(OP_SHL, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0021);
        check("shl_operand_2", operand_2, 32'h0000_0001);
        drain();

        issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007);
        issue(OP_ADD, 3'd5, 3'd0, 3'd1, 1'b0, 16'h0000);
        drain();

        ready_mode = 0;
        issue(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        d0 = out_data;
        c0 = retired_count;
        check("hold_first_data", d0, 32'h0000_0002);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_out_data", out_data, d0);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_retired", {16'b0, retired_count}, {16'b0, c0});
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        drain();
        check("hold_single_wb", {16'b0, retired_count}, {16'b0, c0 + 16'd1});
        issue(OP_ADD, 3'd7, 3'd6, 3'd0, 1'b0, 16'h0000);
        drain();

        ready_mode = 2;
        repeat (150) begin
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 16'($urandom));
        end
        drain();
        ready_mode = 1;

        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        exp_retired = 16'd0;
        #1;
        check("midrst_retired", {16'b0, retired_count}, 32'd0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_wb", {16'b0, retired_count}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            issue(OP_OR, 3'd0, 3'(i), 3'(i), 1'b0, 16'h0000);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
